// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one pipelined single-precision adder
// among NREQ requesters. Each issued op carries a requester-id tag through a
// pipe that runs alongside the adder. Results land in a result FIFO and are
// returned in issue order. Credits limit issue so the FIFO never overflows.
module fadd_arbiter #(
    parameter int NREQ  = 4,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_y,
    output logic [31:0]          fadd_a,
    output logic [31:0]          fadd_b,
    input  logic [31:0]          fadd_y,
    output logic                 busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [IDW-1:0] id_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] data;
    } entry_t;

    // Round-robin pointer and issue credits
    id_t           ptr;
    logic [CW-1:0] credits;

    // Grant decode
    logic          grant_any;
    id_t           grant_id;

    // Tag pipe running in step with the adder
    logic          tag_vld [LAT];
    id_t           tag_id  [LAT];

    // Result FIFO
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    entry_t        head;
    logic          push;
    logic          pop;

    // Advance a FIFO pointer with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    // Grant search: first valid requester at or after ptr, only while credits remain.
    always_comb begin
        int j;
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        grant_any = 1'b0;
        grant_id  = '0;
        j         = 0;
        if (credits != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(ptr) + k;
                if (j >= NREQ)
                    j = j - NREQ;
                if (!grant_any && req_valid[j]) begin
                    grant_any = 1'b1;
                    grant_id  = id_t'(j);
                end
            end
        end
    end

    // Drive the one-hot ready and route the granted operands to the adder.
    always_comb begin
        req_ready = '0;
        fadd_a    = '0;
        fadd_b    = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            fadd_a              = req_a[32*grant_id +: 32];
            fadd_b              = req_b[32*grant_id +: 32];
        end
    end

    // Round-robin pointer moves past the winner; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset)
            ptr <= '0;
        else if (grant_any)
            ptr <= (grant_id == id_t'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // Tag pipe: stage0 takes the current grant, later stages shift it along.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
            end
        end else begin
            tag_vld[0] <= grant_any;
            tag_id[0]  <= grant_id;
            for (int k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // FIFO handshake: capture when the tag pipe reports a finished sum, pop when
    // the owner of the head accepts it.
    always_comb begin
        push = tag_vld[LAT-1];
        head = mem[rd_ptr];
        pop  = (fifo_count != '0) && resp_ready[head.id];
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: FIFO storage is not reset; fifo_count and the pointers alone
        // decide which entries are meaningful.
        if (push)
            mem[wr_ptr] <= '{id: tag_id[LAT-1], data: fadd_y};
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Credits: one is consumed per issue and returned per pop.
    always_ff @(posedge clk) begin
        if (reset)
            credits <= CW'(DEPTH);
        else if (grant_any && !pop)
            credits <= credits - 1'b1;
        else if (pop && !grant_any)
            credits <= credits + 1'b1;
    end

    // Present the FIFO head to its owner; outputs read zero while empty.
    always_comb begin
        resp_valid = '0;
        resp_y     = '0;
        if (fifo_count != '0) begin
            resp_valid[head.id] = 1'b1;
            resp_y              = head.data;
        end
    end

    // Busy while any op is in the adder or any result waits in the FIFO.
    always_comb begin
        busy = (fifo_count != '0);
        for (int k = 0; k < LAT; k++)
            busy = busy | tag_vld[k];
    end

    // The credit scheme must make a push into a full FIFO impossible.
    always @(posedge clk) begin
        if (!reset)
            assert (!(push && fifo_count == CW'(DEPTH)));
    end

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb_fadd_arbiter: drives fadd_arbiter with directed and random traffic, models
// the external adder, and compares every output each cycle against a queue-based
// model of the issue/return behaviour.
module tb_fadd_arbiter;

    localparam int NREQ  = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a = '0;
    logic [32*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready = '0;
    logic [31:0]          resp_y;
    logic [31:0]          fadd_a;
    logic [31:0]          fadd_b;
    logic [31:0]          fadd_y;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    fadd_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .fadd_a     (fadd_a),
        .fadd_b     (fadd_b),
        .fadd_y     (fadd_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    // Operands are floats holding small non-negative integers, so the sum is exact.
    function automatic int fp_to_int(input logic [31:0] x);
        int          e;
        logic [31:0] m;
        if (x[30:0] == 31'd0)
            return 0;
        e = int'(x[30:23]) - 127;
        m = {8'd0, 1'b1, x[22:0]};
        if (e >= 23)
            return int'(m << (e - 23));
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] int_to_fp(input int n);
        int          p;
        logic [31:0] u;
        logic [31:0] m;
        if (n <= 0)
            return 32'd0;
        u = n;
        p = 0;
        for (int k = 0; k < 31; k++)
            if (u[k]) p = k;
        m = u << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return int_to_fp(fp_to_int(a) + fp_to_int(b));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------- adder stand-in
    logic [31:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= fp_add(fadd_a, fadd_b);
        for (int k = 1; k < LAT; k++)
            add_pipe[k] <= add_pipe[k-1];
    end
    assign fadd_y = add_pipe[LAT-1];

    // ------------------------------------------------------- reference model
    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] y;
    } op_t;

    op_t inflight [$];
    op_t fifo_q   [$];
    int  m_ptr = 0;
    int  cyc   = 0;
    int  dut_issue [NREQ];
    int  dut_pop   [NREQ];

    function automatic void m_grant(output bit g, output int gid);
        int credits;
        int j;
        g       = 1'b0;
        gid     = 0;
        credits = DEPTH - inflight.size() - fifo_q.size();
        if (credits > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!g && req_valid[j] === 1'b1) begin
                    g   = 1'b1;
                    gid = j;
                end
            end
        end
    endfunction

    function automatic void clear_counts();
        for (int i = 0; i < NREQ; i++) begin
            dut_issue[i] = 0;
            dut_pop[i]   = 0;
        end
    endfunction

    // Model state advance at each rising edge.
    always @(posedge clk) begin
        bit  g;
        int  gid;
        op_t o;
        if (reset) begin
            inflight.delete();
            fifo_q.delete();
            m_ptr = 0;
        end else begin
            m_grant(g, gid);
            if (fifo_q.size() > 0 && resp_ready[fifo_q[0].id] === 1'b1)
                void'(fifo_q.pop_front());
            while (inflight.size() > 0 && inflight[0].cyc + LAT == cyc)
                fifo_q.push_back(inflight.pop_front());
            if (g) begin
                o.cyc = cyc;
                o.id  = gid;
                o.y   = fp_add(req_a[32*gid +: 32], req_b[32*gid +: 32]);
                inflight.push_back(o);
                m_ptr = (gid + 1) % NREQ;
            end
        end
        cyc++;
    end

    // Compare every DUT output with the model each cycle, away from the edge.
    always @(negedge clk) begin
        bit              g;
        int              gid;
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_rv;
        logic [31:0]     e_a;
        logic [31:0]     e_b;
        logic [31:0]     e_y;
        if (!reset) begin
            m_grant(g, gid);
            e_ready = '0;
            e_a     = '0;
            e_b     = '0;
            if (g) begin
                e_ready[gid] = 1'b1;
                e_a          = req_a[32*gid +: 32];
                e_b          = req_b[32*gid +: 32];
            end
            e_rv = '0;
            e_y  = '0;
            if (fifo_q.size() > 0) begin
                e_rv[fifo_q[0].id] = 1'b1;
                e_y                = fifo_q[0].y;
            end
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("fadd_a", fadd_a, e_a);
            check("fadd_b", fadd_b, e_b);
            check("resp_valid", 32'(resp_valid), 32'(e_rv));
            check("resp_y", resp_y, e_y);
            check("busy", 32'(busy), 32'(inflight.size() > 0 || fifo_q.size() > 0));
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i])   dut_issue[i]++;
                if (resp_valid[i] && resp_ready[i]) dut_pop[i]++;
            end
        end
    end

    // ------------------------------------------------------------- sequences
    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic drain(input string tag);
        int n;
        n          = 0;
        req_valid  = '0;
        resp_ready = '1;
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin
            tick();
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(busy), 32'd0);
        for (int i = 0; i < NREQ; i++)
            check({tag, "_returned_once"}, dut_pop[i], dut_issue[i]);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Single op from requester 0: 1.0 + 2.0 returns 3.0 two cycles later.
        do_reset();
        req_valid        = 4'b0001;
        req_a[31:0]      = 32'h3F80_0000;
        req_b[31:0]      = 32'h4000_0000;
        @(negedge clk);
        check("t1_grant", 32'(req_ready), 32'h1);
        check("t1_fadd_a", fadd_a, 32'h3F80_0000);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_resp_early", 32'(resp_valid), 32'h0);
        tick();
        @(negedge clk);
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_y", resp_y, 32'h4040_0000);
        drain("t1");

        // All requesters valid for 8 cycles: strict rotation, one result per cycle.
        do_reset();
        resp_ready = '1;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 8) ? '1 : '0;
            for (int j = 0; j < NREQ; j++) begin
                req_a[32*j +: 32] = int_to_fp(i * 10 + j);
                req_b[32*j +: 32] = int_to_fp(j + 1);
            end
            @(negedge clk);
            if (i < 8) check("t2_grant_order", 32'(req_ready), 32'(1 << (i % 4)));
            if (i >= 2) check("t2_resp_order", 32'(resp_valid), 32'(1 << ((i - 2) % 4)));
            tick();
        end
        drain("t2");

        // Backpressure: exactly DEPTH issues, then stall; a pop at zero credits
        // does not issue in the same cycle, the next cycle grants.
        do_reset();
        req_valid = 4'b0010;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            req_a[63:32] = int_to_fp(100 + i);
            req_b[63:32] = int_to_fp(i);
            @(negedge clk);
            if (req_ready[1]) n++;
            tick();
        end
        check("t3_issue_count", n, 4);
        @(negedge clk);
        check("t3_stalled_ready", 32'(req_ready), 32'h0);
        check("t3_busy", 32'(busy), 32'h1);
        tick();
        resp_ready = 4'b0010;
        @(negedge clk);
        check("t4_no_issue_at_zero_credit", 32'(req_ready), 32'h0);
        check("t4_head_owner", 32'(resp_valid), 32'h2);
        tick();
        @(negedge clk);
        check("t4_grant_after_pop", 32'(req_ready), 32'h2);
        tick();
        for (int i = 0; i < 12; i++) begin
            req_a[63:32] = int_to_fp(200 + i);
            tick();
        end
        drain("t3");

        // Reset with ops in flight: everything discarded, pointer back to 0.
        do_reset();
        req_valid   = 4'b0011;
        req_a[63:0] = {int_to_fp(7), int_to_fp(5)};
        req_b[63:0] = {int_to_fp(1), int_to_fp(2)};
        tick();
        tick();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
        clear_counts();
        req_valid = '1;
        @(negedge clk);
        check("t5_resp_after_reset", 32'(resp_valid), 32'h0);
        check("t5_busy_after_reset", 32'(busy), 32'h0);
        check("t5_ptr_zero", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t5_no_stale", 32'(resp_valid), 32'h0);
        tick();
        @(negedge clk);
        check("t5_fresh_result", 32'(resp_valid), 32'h1);
        tick();
        drain("t5");

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) begin
                req_a[32*j +: 32] = int_to_fp($urandom_range(0, 1000));
                req_b[32*j +: 32] = int_to_fp($urandom_range(0, 1000));
                resp_ready[j]     = ($urandom_range(0, 9) < 7);
            end
            tick();
        end
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
